// File: rtl/mem_stage_controller.sv
// MEM-stage SRAM access controller: runs one fixed-latency word access
// per load/store and freezes the pipeline via ready until it completes.
module mem_stage_controller #(
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       st_val,
    output logic              ready,
    output logic [31:0]       read_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       is_read;
    logic       request;
    logic       last;

    assign request = mem_read_en | mem_write_en;
    assign last    = (cnt == 4'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (request) state_nxt = ACCESS;
            ACCESS:  if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = ((state == IDLE) && !request) || (state == DONE);
    end

    // Strobes are registered so they go low exactly while state is ACCESS;
    // a simultaneous read and write request resolves to a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            is_read    <= 1'b0;
            read_data  <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        cnt        <= '0;
                        is_read    <= mem_read_en;
                        sram_addr  <= ADDR_W'((alu_res - BASE_ADDR) >> 2);
                        sram_wdata <= st_val;
                        sram_we_n  <= mem_read_en;
                        sram_oe_n  <= ~mem_read_en;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        if (is_read) read_data <= sram_rdata;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
